// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: request opcodes, access lengths and FSM encodings shared by mem_ctrl
package mem_ctrl_pkg;
  localparam logic [1:0] MEM_NOP  = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;
  localparam logic [1:0] MEM_SAVE = 2'd2;
  localparam logic [1:0] MEM_RSV  = 2'd3;
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd3;
  localparam logic [31:0] ZeroWord = 32'h0;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  function automatic logic is_access(input logic [1:0] op);
    return op != MEM_NOP && op != MEM_RSV;
  endfunction
  function automatic logic [2:0] byte_cnt(input logic [1:0] len);
    return len == MEM_BYTE ? 3'd1 : len == MEM_HALF ? 3'd2 : len == MEM_WORD ? 3'd4 : 3'd3;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial MEM/IF controller on the 8-bit RAM/IO bus; define MEMCTL_IO_STALL_EN to stall IO writes while io_buffer_full
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IO_HI  = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [1:0]        memctl_op,
  input  logic [1:0]        memctl_len,
  input  logic [ADDR_W-1:0] memctl_addr,
  input  logic [31:0]       memctl_data,
  output logic              memctl_fin,
  output logic [31:0]       memctl_out,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_fin,
  output logic [31:0]       if_ins,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  state_t            r_state;
  logic              r_is_if;
  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [2:0]        r_n;
  logic [2:0]        r_k;
  logic              w_mem_req;
  logic              w_save;
  logic              w_io;
  logic              w_stall;
  logic [1:0]        w_cap;
  assign w_mem_req = is_access(memctl_op);
  assign w_save    = w_mem_req && memctl_op != MEM_LOAD;
  assign w_cap     = r_k[1:0] - 2'd1;
  assign w_io      = r_addr[IO_HI -: 2] == 2'b11;
`ifdef MEMCTL_IO_STALL_EN
  assign w_stall = w_io && io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = w_io ^ io_buffer_full;
  assign w_stall     = 1'b0;
`endif
  assign mem_a      = r_addr + ADDR_W'(r_k);
  assign mem_dout   = r_data[{r_k[1:0], 3'b000} +: 8];
  assign mem_wr     = rdy_in && r_state == S_WRITE && !w_stall;
  assign memctl_fin = rdy_in && r_state == S_DONE && !r_is_if;
  assign if_fin     = rdy_in && r_state == S_DONE && r_is_if;
  assign memctl_out = r_data;
  assign if_ins     = r_data;
  // arbitration, byte sequencing and read assembly; a freeze drops any pending capture and rewinds k
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_is_if <= 1'b0;
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_data  <= ZeroWord;
      r_n     <= 3'd0;
      r_k     <= 3'd0;
    end else if (!rdy_in) begin
      if (r_pend) begin
        r_k    <= r_k - 3'd1;
        r_pend <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (w_mem_req || if_req) begin
          r_is_if <= !w_mem_req;
          r_addr  <= w_mem_req ? memctl_addr : if_addr;
          r_data  <= w_save ? memctl_data : ZeroWord;
          r_n     <= w_mem_req ? byte_cnt(memctl_len) : 3'd4;
          r_k     <= 3'd0;
          r_pend  <= 1'b0;
          r_state <= w_save ? S_WRITE : S_READ;
        end
        S_READ: begin
          if (r_pend) r_data[{w_cap, 3'b000} +: 8] <= mem_din;
          r_pend <= r_k < r_n;
          if (r_k == r_n) r_state <= S_DONE;
          else r_k <= r_k + 3'd1;
        end
        S_WRITE: if (!w_stall) begin
          r_k <= r_k + 3'd1;
          if (r_k + 3'd1 == r_n) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
